// File: rtl/reduce_pkg.sv
// ----------------------------------------------------------------------------
// reduce_pkg
//   Shared definitions for the pipelined reduction tree (or_reduce_pipe).
//   - mode_e      : per-sample reduction mode encodings
//   - clog_base   : number of tree levels needed to fold n bits with fan-in b
//   - stage_w     : width of the partial-result vector entering level k
//   - stage_off   : bit offset of level k's vector inside the flat tree bus
//   - tree_w      : total width of the flat tree bus (all levels + final bit)
//   - pad_bit     : identity element used to fill short node groups
// ----------------------------------------------------------------------------
package reduce_pkg;

    typedef enum logic [1:0] {
        MODE_OR  = 2'b00,
        MODE_AND = 2'b01,
        MODE_XOR = 2'b10,
        MODE_NOR = 2'b11
    } mode_e;

    // Levels needed so that b**levels >= n; never less than one register stage.
    function automatic int clog_base(input int n, input int b);
        int s;
        int v;
        s = 0;
        v = 1;
        while (v < n) begin
            v = v * b;
            s = s + 1;
        end
        if (s < 1) s = 1;
        return s;
    endfunction

    // Width of the vector entering level k (k=0 is the raw input word).
    function automatic int stage_w(input int n, input int b, input int k);
        int w;
        w = n;
        for (int i = 0; i < k; i++) w = (w + b - 1) / b;
        return w;
    endfunction

    // Levels are packed back to back in one bus so every bit is both driven
    // and consumed; this returns where level k starts.
    function automatic int stage_off(input int n, input int b, input int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) o = o + stage_w(n, b, i);
        return o;
    endfunction

    function automatic int tree_w(input int n, input int b);
        return stage_off(n, b, clog_base(n, b) + 1);
    endfunction

    // Identity for the node operator: AND needs 1, OR/XOR (and NOR, which is
    // OR inside the tree) need 0.
    function automatic logic pad_bit(input logic [1:0] mode);
        return (mode == MODE_AND);
    endfunction

endpackage

// File: rtl/reduce_stage.sv
// ----------------------------------------------------------------------------
// reduce_stage
//   One registered level of the reduction tree. Splits IN_W bits into groups
//   of FANIN, reduces each group with the operator selected by in_mode and
//   registers the NODES results together with the mode and valid bit, so the
//   sample's mode travels down the pipe alongside its data.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-high reset
//   in_valid   in   1       valid bit entering this level
//   in_mode    in   2       reduction mode of the sample entering this level
//   in_data    in   IN_W    partial results from the previous level
//   out_valid  out  1       registered valid
//   out_mode   out  2       registered mode
//   out_data   out  NODES   registered node results
// ----------------------------------------------------------------------------
module reduce_stage
    import reduce_pkg::*;
#(
    parameter  int IN_W  = 16,
    parameter  int FANIN = 4,
    localparam int NODES = (IN_W + FANIN - 1) / FANIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_mode,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    output logic [1:0]       out_mode,
    output logic [NODES-1:0] out_data
);

    localparam int PAD_W = NODES * FANIN;

    logic [PAD_W-1:0] padded;
    logic [FANIN-1:0] grp;
    logic [NODES-1:0] node_d;

    // Fill the tail of the last group with the identity so a short group
    // does not disturb the result.
    always_comb begin
        padded = {PAD_W{pad_bit(in_mode)}};
        padded[IN_W-1:0] = in_data;
        grp    = '0;
        node_d = '0;
        for (int n = 0; n < NODES; n++) begin
            grp = padded[n*FANIN +: FANIN];
            case (in_mode)
                MODE_AND: node_d[n] = &grp;
                MODE_XOR: node_d[n] = ^grp;
                default:  node_d[n] = |grp;   // OR, and NOR before its final inversion
            endcase
        end
    end

    // Data and mode follow the sample whether or not it is valid; only the
    // valid bit decides whether the result is ever looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mode  <= MODE_OR;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            out_mode  <= in_mode;
            out_data  <= node_d;
        end
    end

endmodule

// File: rtl/or_reduce_pipe.sv
// ----------------------------------------------------------------------------
// or_reduce_pipe
//   Pipelined N_IN-bit reduction (OR / AND / XOR / NOR selectable per sample)
//   built from STAGES registered levels of FANIN-input nodes. Result appears
//   STAGES cycles after acceptance at full throughput. Also keeps a sticky
//   "any result was 1" flag and a saturating count of results equal to 1.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      in_data/in_mode valid this cycle
//   in_data    in   N_IN   bits to reduce
//   in_mode    in   2      00 OR, 01 AND, 10 XOR, 11 NOR
//   clr        in   1      synchronous clear of sticky and hit_cnt
//   out_valid  out  1      out_data valid
//   out_data   out  1      reduction result
//   sticky     out  1      set by any valid 1 result since last clr/reset
//   hit_cnt    out  CNT_W  saturating count of valid 1 results
// ----------------------------------------------------------------------------
module or_reduce_pipe
    import reduce_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int FANIN = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_data,
    input  logic [1:0]       in_mode,
    input  logic             clr,
    output logic             out_valid,
    output logic             out_data,
    output logic             sticky,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int STAGES = clog_base(N_IN, FANIN);
    localparam int TREE_W = tree_w(N_IN, FANIN);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // All levels of the tree live in one flat bus: level k occupies
    // tree[stage_off(k) +: stage_w(k)], the last level is the single top bit.
    logic [TREE_W-1:0]       tree;
    logic [STAGES:0]         vld_pipe;
    logic [STAGES:0][1:0]    mode_pipe;
    logic                    hit;

    assign tree[N_IN-1:0] = in_data;
    assign vld_pipe[0]    = in_valid;
    assign mode_pipe[0]   = in_mode;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int IW   = stage_w(N_IN, FANIN, k);
        localparam int OW   = stage_w(N_IN, FANIN, k + 1);
        localparam int IOFF = stage_off(N_IN, FANIN, k);
        localparam int OOFF = stage_off(N_IN, FANIN, k + 1);

        reduce_stage #(
            .IN_W  (IW),
            .FANIN (FANIN)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld_pipe[k]),
            .in_mode   (mode_pipe[k]),
            .in_data   (tree[IOFF +: IW]),
            .out_valid (vld_pipe[k+1]),
            .out_mode  (mode_pipe[k+1]),
            .out_data  (tree[OOFF +: OW])
        );
    end

    // NOR is an OR all the way down the tree; invert only the final bit.
    // The stage registers reset to OR mode with zero data, so out_data is 0
    // while in reset.
    assign out_valid = vld_pipe[STAGES];
    assign out_data  = tree[TREE_W-1] ^ (mode_pipe[STAGES] == MODE_NOR);
    assign hit       = out_valid & out_data;

    // A hit in the same cycle as clr wins: sticky stays set and the counter
    // restarts at one rather than zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky  <= 1'b0;
            hit_cnt <= '0;
        end else begin
            if (hit)
                sticky <= 1'b1;
            else if (clr)
                sticky <= 1'b0;

            if (clr)
                hit_cnt <= hit ? CNT_W'(1) : '0;
            else if (hit && (hit_cnt != CNT_MAX))
                hit_cnt <= hit_cnt + 1'b1;
        end
    end

endmodule
